tune_ctrl: RTL and testbench
============================

# tune_ctrl

Serial command front-end that sits between the UART receiver/transmitter and the NCO/CIC chain. It assembles framed byte commands from the receiver, validates them, and holds the live 64-bit NCO phase increment and the 16-bit CIC decimation ratio, replacing the fixed constants currently wired at top level. Each frame is acknowledged (ACK/NAK) through the UART transmitter byte handshake.

## Interface
Parameters:
- `PHASE_INC_RST`, 64'h104376A9DD10437, phase increment loaded at reset (540 kHz at 136 MHz)
- `DEC_RST`, 16'd4096, decimation ratio loaded at reset
- `TIMEOUT_CLKS`, 24'd1_360_000, max clocks between bytes of one frame (~10 ms)

Ports:
- `clk`  in  1  system clock (`osc_clk` domain)
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `rx_dv`  in  1  one-cycle strobe: `rx_byte` valid
- `rx_byte`  in  8  received byte
- `tx_busy`  in  1  transmitter busy; a byte offered while high is not taken
- `tx_dv`  out  1  one-cycle strobe: `tx_byte` valid
- `tx_byte`  out  8  response byte
- `phase_inc`  out  64  NCO phase increment
- `dec_ratio`  out  16  CIC decimation ratio
- `update`  out  1  one-cycle pulse when either register changes
- `err_cnt`  out  8  saturating count of rejected/timed-out frames

## Operation
- Frame: SYNC 0xA5, CMD, 8 payload bytes MSB first, CSUM (XOR of CMD and all 8 payload bytes).
- CMD 0x01: payload -> `phase_inc`. CMD 0x02: payload[15:0] -> `dec_ratio`; payload[15:0] < 2 is invalid.
- States: IDLE, CMD, DATA, CSUM, APPLY, RESP.
  - IDLE: on `rx_dv` with 0xA5 -> CMD; other bytes are discarded.
  - CMD: latch byte -> DATA, byte counter = 0.
  - DATA: shift byte into 64-bit shift register; after 8th byte -> CSUM.
  - CSUM: compare with running XOR -> APPLY.
  - APPLY (one cycle): if valid (known CMD, CSUM match, range ok), load target register, pulse `update`, response = 0x06; else response = 0x15, `err_cnt` += 1 (saturate at 255). -> RESP.
  - RESP: wait until `tx_busy`=0, assert `tx_dv` one cycle with response -> IDLE.
- Unknown CMD still consumes the full frame before NAK.
- `rx_dv` in APPLY or RESP: byte dropped.
- Timeout: in CMD/DATA/CSUM, counter clears on each `rx_dv`; reaching `TIMEOUT_CLKS` -> IDLE, `err_cnt` += 1, no response.

## Timing
- Reset values: `phase_inc`=`PHASE_INC_RST`, `dec_ratio`=`DEC_RST`, `tx_dv`=0, `tx_byte`=0, `update`=0, `err_cnt`=0, state IDLE.
- Final byte strobed at cycle N -> APPLY at N+1; new `phase_inc`/`dec_ratio` and `update`=1 visible at N+2.
- `tx_dv` earliest at N+2 (RESP entry with `tx_busy`=0); otherwise first cycle after `tx_busy` falls.
- All outputs registered; no combinational path from inputs to outputs.
- `rst_n` mid-frame: partial frame discarded, registers return to reset values.

## Configuration
- `TUNE_CTRL_CSUM_EN` defined: frame includes CSUM, mismatch -> NAK.
- Undefined: no CSUM state; DATA goes straight to APPLY after 8th payload byte (final byte is payload byte 8); validity = known CMD and range only.

## Structure
- Shared package `sdr_pkg`: SYNC byte 0xA5, ACK 0x06, NAK 0x15, CMD codes 0x01/0x02, state enum encoding.
- Single module, no sub-modules; timeout counter and XOR accumulator inline.

## Test plan
- Reset release, no traffic -> `phase_inc`=64'h104376A9DD10437, `dec_ratio`=4096, `tx_dv` never asserts.
- Frame A5 01 01 B1 B1 B1 B1 B1 B1 B1 + correct CSUM -> `phase_inc`=64'h01B1B1B1B1B1B1B1 at N+2, `update` one cycle, `tx_byte`=0x06.
- Frame CMD 0x02, payload low 16 = 0x0800, corrupted CSUM -> NAK 0x15, `dec_ratio` stays 4096, `err_cnt`=1.
- CMD 0x02 payload 0x0001 with valid CSUM -> NAK, no `update`.
- Stop after 3 payload bytes for > `TIMEOUT_CLKS` -> IDLE, `err_cnt` +1, no `tx_dv`; next valid frame accepted normally.
- Valid frame with `tx_busy` held high 50 cycles after APPLY -> `tx_dv` asserted exactly one cycle, first cycle `tx_busy`=0; byte arriving during wait is dropped.

Source files
------------

// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared protocol constants and FSM state encoding for the tuning command front-end
package sdr_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [7:0] CMD_PHASE = 8'h01;
    localparam logic [7:0] CMD_DEC   = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_APPLY = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/tune_ctrl.sv
// rtl/tune_ctrl.sv - serial command front-end holding the live NCO phase increment and CIC decimation ratio
//
// Assembles framed commands (SYNC, CMD, 8 payload bytes MSB first[, CSUM]) from the
// UART receiver, validates them, loads the target register and answers ACK/NAK
// through the UART transmitter byte handshake.
//
// Build option: TUNE_CTRL_CSUM_EN - frame carries a trailing XOR checksum byte.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx_dv      one-cycle strobe, rx_byte valid
//   rx_byte    received byte
//   tx_busy    transmitter busy; a byte offered while high is not taken
//   tx_dv      one-cycle strobe, tx_byte valid
//   tx_byte    response byte (ACK/NAK)
//   phase_inc  NCO phase increment
//   dec_ratio  CIC decimation ratio
//   update     one-cycle pulse when a register is loaded
//   err_cnt    saturating count of rejected or timed-out frames
module tune_ctrl
    import sdr_pkg::*;
#(
    parameter logic [63:0] PHASE_INC_RST = 64'h0104376A9DD10437,
    parameter logic [15:0] DEC_RST       = 16'd4096,
    parameter logic [23:0] TIMEOUT_CLKS  = 24'd1_360_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        tx_busy,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic [63:0] phase_inc,
    output logic [15:0] dec_ratio,
    output logic        update,
    output logic [7:0]  err_cnt
);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cmd_q;
    logic [63:0] shift_q;
    logic [2:0]  byte_cnt;
    logic [7:0]  xor_q;
    logic [23:0] tmo_cnt;
    logic [7:0]  resp_q;
`ifdef TUNE_CTRL_CSUM_EN
    logic        csum_ok_q;
`endif

    logic        in_frame;
    logic        tmo_hit;
    logic        frame_ok;
    logic        emit;
    logic [7:0]  resp_now;
    logic        load_phase;
    logic        load_dec;
    logic        err_inc;

    // Only the frame-body states are subject to the inter-byte timeout.
    assign in_frame = (state == ST_CMD) || (state == ST_DATA) || (state == ST_CSUM);
    assign tmo_hit  = in_frame && !rx_dv && (tmo_cnt == TIMEOUT_CLKS - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rx_dv && rx_byte == SYNC_BYTE) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end else if (rx_dv) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end else if (rx_dv && byte_cnt == 3'd7) begin
`ifdef TUNE_CTRL_CSUM_EN
                    state_nxt = ST_CSUM;
`else
                    state_nxt = ST_APPLY;
`endif
                end
            end
            ST_CSUM: begin
                if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end else if (rx_dv) begin
                    state_nxt = ST_APPLY;
                end
            end
            // When the transmitter is free already in APPLY the response goes out
            // on the same edge that leaves APPLY, so RESP is only a wait state.
            ST_APPLY: state_nxt = emit ? ST_IDLE : ST_RESP;
            ST_RESP:  state_nxt = emit ? ST_IDLE : ST_RESP;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_ok = (cmd_q == CMD_PHASE) ||
                   ((cmd_q == CMD_DEC) && (shift_q[15:0] >= 16'd2));
`ifdef TUNE_CTRL_CSUM_EN
        frame_ok = frame_ok && csum_ok_q;
`endif
        emit       = ((state == ST_APPLY) || (state == ST_RESP)) && !tx_busy;
        resp_now   = (state == ST_APPLY) ? (frame_ok ? ACK_BYTE : NAK_BYTE) : resp_q;
        load_phase = (state == ST_APPLY) && frame_ok && (cmd_q == CMD_PHASE);
        load_dec   = (state == ST_APPLY) && frame_ok && (cmd_q == CMD_DEC);
        err_inc    = ((state == ST_APPLY) && !frame_ok) || tmo_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= 8'h00;
            shift_q  <= 64'h0;
            byte_cnt <= 3'd0;
            xor_q    <= 8'h00;
            tmo_cnt  <= 24'd0;
            resp_q   <= NAK_BYTE;
`ifdef TUNE_CTRL_CSUM_EN
            csum_ok_q <= 1'b0;
`endif
        end else begin
            if (!in_frame || rx_dv) begin
                tmo_cnt <= 24'd0;
            end else begin
                tmo_cnt <= tmo_cnt + 24'd1;
            end

            if (rx_dv && state == ST_CMD) begin
                cmd_q    <= rx_byte;
                xor_q    <= rx_byte;
                byte_cnt <= 3'd0;
            end

            if (rx_dv && state == ST_DATA) begin
                shift_q  <= {shift_q[55:0], rx_byte};
                xor_q    <= xor_q ^ rx_byte;
                byte_cnt <= byte_cnt + 3'd1;
            end

`ifdef TUNE_CTRL_CSUM_EN
            if (rx_dv && state == ST_CSUM) begin
                csum_ok_q <= (rx_byte == xor_q);
            end
`endif

            if (state == ST_APPLY) begin
                resp_q <= resp_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_inc <= PHASE_INC_RST;
            dec_ratio <= DEC_RST;
            update    <= 1'b0;
            err_cnt   <= 8'd0;
            tx_dv     <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            if (load_phase) begin
                phase_inc <= shift_q;
            end
            if (load_dec) begin
                dec_ratio <= shift_q[15:0];
            end
            update <= load_phase || load_dec;
            if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
            tx_dv <= emit;
            if (emit) begin
                tx_byte <= resp_now;
            end
        end
    end

endmodule

// File: tb/tb_tune_ctrl.sv
// tb/tb_tune_ctrl.sv - self-checking bench for tune_ctrl with a frame-level reference model
module tb_tune_ctrl;

    localparam logic [63:0] PH_RST = 64'h0104376A9DD10437;
    localparam logic [15:0] DC_RST = 16'd4096;
    localparam logic [23:0] TMO    = 24'd64;
`ifdef TUNE_CTRL_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        tx_busy;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic [63:0] phase_inc;
    logic [15:0] dec_ratio;
    logic        update;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;
    int tx_seen = 0;
    int upd_seen = 0;
    int exp_tx = 0;
    int exp_upd = 0;

    logic [63:0] m_phase;
    logic [15:0] m_dec;
    int          m_err;

    tune_ctrl #(
        .PHASE_INC_RST(PH_RST),
        .DEC_RST(DC_RST),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_dv(rx_dv),
        .rx_byte(rx_byte),
        .tx_busy(tx_busy),
        .tx_dv(tx_dv),
        .tx_byte(tx_byte),
        .phase_inc(phase_inc),
        .dec_ratio(dec_ratio),
        .update(update),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_dv)  tx_seen++;
        if (update) upd_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        tick();
        rx_dv = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    task automatic gap_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(b);
    endtask

    // Sends one complete frame, then checks the outcome against the model.
    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] pl,
                              input bit corrupt, input int busy_hold);
        logic [7:0] cs;
        bit         ok;
        cs = cmd;
        for (int i = 0; i < 8; i++) cs = cs ^ pl[63 - 8*i -: 8];
        ok = ((cmd == 8'h01) || (cmd == 8'h02 && pl[15:0] >= 16'd2)) && !(corrupt && CSUM_ON);
        tx_busy = (busy_hold > 0);
        gap_byte(8'hA5);
        gap_byte(cmd);
        for (int i = 0; i < 8; i++) gap_byte(pl[63 - 8*i -: 8]);
`ifdef TUNE_CTRL_CSUM_EN
        gap_byte(corrupt ? (cs ^ 8'h5A) : cs);
`endif
        if (ok) begin
            if (cmd == 8'h01) m_phase = pl;
            else m_dec = pl[15:0];
            exp_upd++;
        end else if (m_err < 255) begin
            m_err++;
        end
        exp_tx++;
        tick();
        check("phase_inc", phase_inc, m_phase);
        check("dec_ratio", {48'h0, dec_ratio}, {48'h0, m_dec});
        check("update", {63'h0, update}, {63'h0, ok});
        check("err_cnt", {56'h0, err_cnt}, 64'(m_err));
        if (busy_hold == 0) begin
            check("tx_dv", {63'h0, tx_dv}, 64'h1);
            check("tx_byte", {56'h0, tx_byte}, {56'h0, (ok ? 8'h06 : 8'h15)});
        end else begin
            check("tx_dv_busy", {63'h0, tx_dv}, 64'h0);
            send_byte(8'hA5);
            repeat (busy_hold) tick();
            check("tx_held", 64'(tx_seen), 64'(exp_tx - 1));
            tx_busy = 1'b0;
            tick();
            check("tx_dv_rel", {63'h0, tx_dv}, 64'h1);
            check("tx_byte_rel", {56'h0, tx_byte}, {56'h0, (ok ? 8'h06 : 8'h15)});
        end
        tick();
        check("tx_dv_low", {63'h0, tx_dv}, 64'h0);
        check("update_low", {63'h0, update}, 64'h0);
        check("tx_count", 64'(tx_seen), 64'(exp_tx));
        check("upd_count", 64'(upd_seen), 64'(exp_upd));
    endtask

    task automatic model_reset();
        m_phase = PH_RST;
        m_dec   = DC_RST;
        m_err   = 0;
    endtask

    initial begin
        logic [7:0]  c;
        logic [63:0] p;
        rst_n = 1'b0;
        rx_dv = 1'b0;
        rx_byte = 8'h00;
        tx_busy = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_phase", phase_inc, PH_RST);
        check("rst_dec", {48'h0, dec_ratio}, {48'h0, DC_RST});
        check("rst_tx_byte", {56'h0, tx_byte}, 64'h0);
        check("rst_err", {56'h0, err_cnt}, 64'h0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle_no_tx", 64'(tx_seen), 64'h0);
        check("idle_phase", phase_inc, PH_RST);

        // Reference frame from the command set description.
        send_frame(8'h01, 64'h01B1B1B1B1B1B1B1, 1'b0, 0);
        check("ref_phase", phase_inc, 64'h01B1B1B1B1B1B1B1);

        // Corrupted checksum (rejected only when the checksum byte exists).
        send_frame(8'h02, 64'h1122334455660800, 1'b1, 0);
        // Decimation ratio of 1 is out of range; 2 is the lowest accepted.
        send_frame(8'h02, 64'h0000000000000001, 1'b0, 0);
        send_frame(8'h02, 64'h0000000000000000, 1'b0, 0);
        send_frame(8'h02, 64'hFFFFFFFFFFFF0002, 1'b0, 0);
        send_frame(8'h33, 64'h0123456789ABCDEF, 1'b0, 0);

        // Abandoned frame after 3 payload bytes: silent timeout.
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i));
        repeat (int'(TMO) + 10) tick();
        if (m_err < 255) m_err++;
        check("tmo_err", {56'h0, err_cnt}, 64'(m_err));
        check("tmo_no_tx", 64'(tx_seen), 64'(exp_tx));
        check("tmo_phase", phase_inc, m_phase);
        send_frame(8'h01, 64'hDEADBEEF00C0FFEE, 1'b0, 0);

        // Transmitter busy for 50 cycles after APPLY; a SYNC during the wait is dropped.
        send_frame(8'h02, 64'h0000000000001234, 1'b0, 50);
        send_frame(8'h01, 64'h0000000000000005, 1'b0, 0);

        // Randomized frames with junk bytes between them.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                c = 8'($urandom);
                if (c == 8'hA5) c = 8'h00;
                send_byte(c);
            end
            case ($urandom_range(0, 2))
                0: c = 8'h01;
                1: c = 8'h02;
                default: begin
                    c = 8'($urandom);
                    if (c == 8'h01 || c == 8'h02) c = 8'h7E;
                end
            endcase
            p = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) p[15:0] = 16'($urandom_range(0, 3));
            send_frame(c, p, ($urandom_range(0, 3) == 0), 0);
        end

        // Reset in the middle of a frame.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h99);
        rst_n = 1'b0;
        tick();
        model_reset();
        check("mid_rst_phase", phase_inc, PH_RST);
        check("mid_rst_dec", {48'h0, dec_ratio}, {48'h0, DC_RST});
        check("mid_rst_err", {56'h0, err_cnt}, 64'h0);
        check("mid_rst_tx", {56'h0, tx_byte}, 64'h0);
        rst_n = 1'b1;
        tick();
        send_frame(8'h02, 64'h0000000000000002, 1'b0, 0);

        // Drive the error counter into saturation.
        for (int n = 0; n < 260; n++) send_frame(8'hC3, {$urandom, $urandom}, 1'b0, 0);
        check("err_sat", {56'h0, err_cnt}, 64'd255);
        send_frame(8'h01, 64'h0000000100000001, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
